// File: rtl/motor_mix_scheduler_pkg.sv
// Shared constants, state encodings and the quad-X mix sign table for the
// motor mix scheduler.
package motor_pkg;

    localparam int         SUM_W         = 11;
    localparam logic [7:0] BASE_DUTY_DEF = 8'd50;
    localparam logic [7:0] MAX_DUTY_DEF  = 8'd100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC0,
        S_CALC1,
        S_CALC2,
        S_CALC3,
        S_PUBLISH
    } sched_e;

    typedef enum logic {
        A_DISARMED,
        A_ARMED
    } arm_e;

    // Returns {pitch, roll, yaw} subtract flags for one motor; 1 = subtract.
    function automatic logic [2:0] mix_sign(input logic [1:0] motor);
        logic [2:0] sub;
        case (motor)
            2'd0:    sub = 3'b001;
            2'd1:    sub = 3'b010;
            2'd2:    sub = 3'b111;
            default: sub = 3'b100;
        endcase
        return sub;
    endfunction

endpackage

// File: rtl/motor_mix_scheduler_if.sv
// Offset-sample input bundle and duty/status outputs of the motor mix scheduler.
interface motor_mix_scheduler_if;
    logic       sample_valid;
    logic [7:0] throttle_offset;
    logic [7:0] pitch_offset;
    logic [7:0] roll_offset;
    logic [7:0] yaw_offset;
    logic       arm_req;
    logic [7:0] duty_m0;
    logic [7:0] duty_m1;
    logic [7:0] duty_m2;
    logic [7:0] duty_m3;
    logic       duty_valid;
    logic       busy;
    logic       armed;
    logic       failsafe;

    modport master (
        output sample_valid, throttle_offset, pitch_offset, roll_offset, yaw_offset, arm_req,
        input  duty_m0, duty_m1, duty_m2, duty_m3, duty_valid, busy, armed, failsafe
    );

    modport slave (
        input  sample_valid, throttle_offset, pitch_offset, roll_offset, yaw_offset, arm_req,
        output duty_m0, duty_m1, duty_m2, duty_m3, duty_valid, busy, armed, failsafe
    );
endinterface

// File: rtl/mix_sat_adder.sv
// Combinational five-term signed mix sum (base + T +/- P +/- R +/- Y) clamped
// to [0, MAX_DUTY]; shared across all four motors by the scheduler.
module mix_sat_adder
    import motor_pkg::*;
#(
    parameter logic [7:0] MAX_DUTY = MAX_DUTY_DEF
) (
    input  logic [7:0] base,
    input  logic [7:0] throttle,
    input  logic [7:0] pitch,
    input  logic [7:0] roll,
    input  logic [7:0] yaw,
    input  logic [2:0] sub_sel,
    output logic [7:0] duty
);

    logic signed [SUM_W-1:0] base_ext;
    logic signed [SUM_W-1:0] thr_ext;
    logic signed [SUM_W-1:0] pitch_ext;
    logic signed [SUM_W-1:0] roll_ext;
    logic signed [SUM_W-1:0] yaw_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] max_ext;

    assign base_ext  = signed'({{(SUM_W-8){1'b0}}, base});
    assign thr_ext   = signed'({{(SUM_W-8){1'b0}}, throttle});
    assign max_ext   = signed'({{(SUM_W-8){1'b0}}, MAX_DUTY});
    assign pitch_ext = signed'({{(SUM_W-8){pitch[7]}}, pitch});
    assign roll_ext  = signed'({{(SUM_W-8){roll[7]}}, roll});
    assign yaw_ext   = signed'({{(SUM_W-8){yaw[7]}}, yaw});

    always_comb begin
        sum = base_ext + thr_ext
            + (sub_sel[2] ? -pitch_ext : pitch_ext)
            + (sub_sel[1] ? -roll_ext  : roll_ext)
            + (sub_sel[0] ? -yaw_ext   : yaw_ext);
        if (sum < 0) begin
            duty = 8'd0;
        end else if (sum > max_ext) begin
            duty = MAX_DUTY;
        end else begin
            duty = sum[7:0];
        end
    end

endmodule

// File: rtl/motor_mix_scheduler.sv
// Time-shares one saturating mix adder across four motors on a six-state
// schedule; owns arm/disarm, the receiver-loss watchdog and failsafe latch.
module motor_mix_scheduler
    import motor_pkg::*;
#(
    parameter logic [7:0]  BASE_DUTY   = BASE_DUTY_DEF,
    parameter logic [7:0]  MAX_DUTY    = MAX_DUTY_DEF,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    motor_mix_scheduler_if.slave  bus
);

    sched_e      state_q, state_d;
    arm_e        arm_q, arm_d;
    logic        failsafe_q, failsafe_d;
    logic        rearm_ok_q, rearm_ok_d;
    logic [31:0] wdog_q, wdog_d;
    logic [7:0]  thr_q, thr_d, pitch_q, pitch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [7:0]  shadow_q [3];
    logic [7:0]  shadow_d [3];
    logic [7:0]  duty_q [4];
    logic [7:0]  duty_d [4];
    logic        duty_valid_q, duty_valid_d;
    logic        busy_q, busy_d;

    logic        accept, trip, arming;
    logic [1:0]  motor_idx;
    logic [7:0]  sum_duty, calc_val;

    always_comb begin
        case (state_q)
            S_CALC1: motor_idx = 2'd1;
            S_CALC2: motor_idx = 2'd2;
            S_CALC3: motor_idx = 2'd3;
            default: motor_idx = 2'd0;
        endcase
    end

    mix_sat_adder #(.MAX_DUTY(MAX_DUTY)) u_adder (
        .base     (BASE_DUTY),
        .throttle (thr_q),
        .pitch    (pitch_q),
        .roll     (roll_q),
        .yaw      (yaw_q),
        .sub_sel  (mix_sign(motor_idx)),
        .duty     (sum_duty)
    );

    assign calc_val = (arm_q == A_ARMED && !failsafe_q) ? sum_duty : BASE_DUTY;

    always_comb begin
        accept = (state_q == S_IDLE) && bus.sample_valid;
        // A sample arriving on the expiry cycle wins over the timeout.
        trip   = (wdog_q == TIMEOUT_CYC) && !failsafe_q && !accept;
        arming = accept && bus.arm_req && (bus.throttle_offset == 8'd0)
                 && !failsafe_q && rearm_ok_q;

        state_d      = state_q;
        arm_d        = arm_q;
        failsafe_d   = failsafe_q;
        rearm_ok_d   = rearm_ok_q;
        thr_d        = thr_q;
        pitch_d      = pitch_q;
        roll_d       = roll_q;
        yaw_d        = yaw_q;
        shadow_d     = shadow_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;

        if (accept) begin
            wdog_d = 32'd0;
        end else if (wdog_q == TIMEOUT_CYC) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + 32'd1;
        end

        if (accept) begin
            thr_d      = bus.throttle_offset;
            pitch_d    = bus.pitch_offset;
            roll_d     = bus.roll_offset;
            yaw_d      = bus.yaw_offset;
            failsafe_d = 1'b0;
        end
        if (trip) begin
            failsafe_d = 1'b1;
        end

        if (trip || (arm_q == A_ARMED && !bus.arm_req)) begin
            arm_d = A_DISARMED;
        end else if (arming) begin
            arm_d = A_ARMED;
        end

        // Re-arming needs arm_req to be seen low after any disarm.
        if (trip || arming) begin
            rearm_ok_d = 1'b0;
        end else if (!bus.arm_req) begin
            rearm_ok_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC0;
                end else if (trip) begin
                    state_d      = S_PUBLISH;
                    duty_d       = '{BASE_DUTY, BASE_DUTY, BASE_DUTY, BASE_DUTY};
                    duty_valid_d = 1'b1;
                end
            end
            S_CALC0: begin
                shadow_d[0] = calc_val;
                state_d     = S_CALC1;
            end
            S_CALC1: begin
                shadow_d[1] = calc_val;
                state_d     = S_CALC2;
            end
            S_CALC2: begin
                shadow_d[2] = calc_val;
                state_d     = S_CALC3;
            end
            S_CALC3: begin
                // Outputs load on entry to PUBLISH so duty_valid is high during it.
                state_d      = S_PUBLISH;
                duty_valid_d = 1'b1;
                if (failsafe_q || trip) begin
                    duty_d = '{BASE_DUTY, BASE_DUTY, BASE_DUTY, BASE_DUTY};
                end else begin
                    duty_d = '{shadow_q[0], shadow_q[1], shadow_q[2], calc_val};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            arm_q        <= A_DISARMED;
            failsafe_q   <= 1'b0;
            rearm_ok_q   <= 1'b0;
            wdog_q       <= 32'd0;
            thr_q        <= 8'd0;
            pitch_q      <= 8'd0;
            roll_q       <= 8'd0;
            yaw_q        <= 8'd0;
            duty_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= BASE_DUTY;
            for (int i = 0; i < 4; i++) duty_q[i] <= BASE_DUTY;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            failsafe_q   <= failsafe_d;
            rearm_ok_q   <= rearm_ok_d;
            wdog_q       <= wdog_d;
            thr_q        <= thr_d;
            pitch_q      <= pitch_d;
            roll_q       <= roll_d;
            yaw_q        <= yaw_d;
            duty_valid_q <= duty_valid_d;
            busy_q       <= busy_d;
            shadow_q     <= shadow_d;
            duty_q       <= duty_d;
        end
    end

    assign bus.duty_m0    = duty_q[0];
    assign bus.duty_m1    = duty_q[1];
    assign bus.duty_m2    = duty_q[2];
    assign bus.duty_m3    = duty_q[3];
    assign bus.duty_valid = duty_valid_q;
    assign bus.busy       = busy_q;
    assign bus.armed      = (arm_q == A_ARMED);
    assign bus.failsafe   = failsafe_q;

endmodule
